mc_control: RTL and testbench
=============================

# mc_control

Parametrised multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and write-back for the datapath, and drives all register-enable and mux-select lines. Over the previous controller it adds:
- configurable memory wait states;
- BEQ/BNE resolved from the ALU `zero` flag;
- OR and SLT R-type ops, and a JAL link write;
- an optional overflow trap.

It sits between the instruction register and the datapath, one instance per core.

## Interface
- `MEM_WAIT`, default 1: extra cycles memory needs after the address (read) or data (write) is presented. Legal range 0..15.
- `LINK_REG`, default 31: link register index. Informational only; the datapath maps `mux_regdst`=3 to it.
- `clk` in 1: clock. One clock domain; everything changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: IR[31:26]. `funct` in 6: IR[5:0]. Both are stable from DECODE onward.
- `zero` in 1: ALU result == 0. `overflow` in 1: ALU signed overflow.
- `pc_load`, `ins_load`, `mem_write`, `reg_write`, `regA_load`, `regB_load`, `aluout_load`, `mdr_load` out 1: datapath enables.
- `mux_alusrcA` out 1 (0=PC, 1=A). `mux_alusrcB` out 2 (0=B, 1=4, 2=sign-ext imm, 3=imm<<2).
- `mux_pcin` out 2 (0=ALU, 1=ALUOut, 2=jump target, 3=exception vector). `mux_IorD` out 2 (0=PC, 1=ALUOut).
- `mux_regdst` out 2 (0=rt, 1=rd, 2=SP, 3=link). `mux_mem2reg` out 3 (0=MDR, 1=ALUOut, 2=LUI imm, 3=PC, 6=227).
- `adjsz_ctrl` out 2 (0=word, 1=byte, 2=half). `memow_ctrl` out 2 (0=word, 1=byte, 2=half).
- `alu_op` out 3 (0=pass A, 1=add, 2=sub, 3=and, 4=or, 7=slt).
- `exc` out 1: overflow trap taken.

## Operation
- Moore FSM, 5-bit state register plus a 4-bit wait counter `wcnt`. Outputs decode from state only; the one exception is `pc_load` in BRANCH. Any output not listed for a state is 0.
- IDLE: all outputs 0 → RESET_SP.
- RESET_SP: `reg_write`=1, `mux_regdst`=2, `mux_mem2reg`=6 → FETCH.
- FETCH: `mux_IorD`=0. Loads `wcnt`=MEM_WAIT on entry and stays until `wcnt`==0 → FETCH_IR.
- FETCH_IR: `ins_load`=1, `pc_load`=1, `mux_alusrcB`=1, `alu_op`=1, `mux_pcin`=0 → DECODE.
- DECODE: `regA_load`=`regB_load`=1, `aluout_load`=1, `mux_alusrcB`=3, `alu_op`=1 (branch target).
- DECODE dispatch:
  - 0x00 → EXEC_R
  - 0x08 → EXEC_I
  - 0x0F → WB_LUI
  - 0x23/0x21/0x20/0x2B/0x29/0x28 → MEM_ADDR
  - 0x04/0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL_LINK
  - other → FETCH (no architectural effect)
- EXEC_R: `mux_alusrcA`=1, `mux_alusrcB`=0, `aluout_load`=1. Funct mapping: 0x20→1, 0x22→2, 0x24→3, 0x25→4, 0x2A→7 → WB_ALU. Any other funct → FETCH with no write.
- EXEC_I: as EXEC_R but `mux_alusrcB`=2, `alu_op`=1 → WB_ALU.
- WB_ALU: `reg_write`=1, `mux_mem2reg`=1, `mux_regdst`=1 (R-type) or 0 (ADDI) → FETCH.
- WB_LUI: `reg_write`=1, `mux_regdst`=0, `mux_mem2reg`=2 → FETCH.
- MEM_ADDR: `mux_alusrcA`=1, `mux_alusrcB`=2, `alu_op`=1, `aluout_load`=1. Loads → MEM_RD; stores → MEM_WR.
- MEM_RD: `mux_IorD`=1, waits MEM_WAIT cycles via `wcnt` → MEM_LD.
- MEM_LD: `mux_IorD`=1, `mdr_load`=1 → WB_MEM.
- WB_MEM: `reg_write`=1, `mux_regdst`=0, `mux_mem2reg`=0, `adjsz_ctrl` per opcode (0x23→0, 0x20→1, 0x21→2) → FETCH.
- MEM_WR: `mux_IorD`=1, `mem_write`=1, `memow_ctrl` per opcode (0x2B→0, 0x28→1, 0x29→2). Held MEM_WAIT+1 cycles → FETCH.
- BRANCH: `mux_alusrcA`=1, `mux_alusrcB`=0, `alu_op`=2, `mux_pcin`=1. `pc_load` = `zero` for BEQ, !`zero` for BNE → FETCH.
- JAL_LINK: `reg_write`=1, `mux_regdst`=3, `mux_mem2reg`=3 → JUMP.
- JUMP: `mux_pcin`=2, `pc_load`=1 → FETCH.

## Timing
- `rst` high at an edge: state=IDLE and `wcnt`=0 at that edge, from any state. Every output reads 0 the following cycle, including `mem_write` and `exc`, even if reset arrives mid-write.
- After `rst` falls: IDLE 1 cycle, RESET_SP 1 cycle, then the first FETCH.
- Per-instruction cycles, with W=MEM_WAIT:
  - R/ADDI: W+5
  - LUI, branch, J: W+4
  - JAL: W+5
  - load: 2W+7
  - store: 2W+5
- W=0: FETCH and MEM_RD last exactly 1 cycle each.
- `wcnt` decrements once per cycle in a wait state. It is never read outside FETCH, MEM_RD and MEM_WR.

## Configuration
- `MC_CTRL_OVF_EXC_EN` defined:
  - In WB_ALU for funct 0x20/0x22 or opcode 0x08, if `overflow`==1 the FSM goes to EXC instead of writing. `reg_write` stays 0 for that cycle.
  - EXC lasts 1 cycle: `mux_pcin`=3, `pc_load`=1, `exc`=1 → FETCH.
  - The datapath holds `overflow` from EXEC until WB_ALU.
- Undefined: `overflow` is ignored, `exc` is tied to 0, and the EXC state is absent.

## Test plan
- Reset: `rst` held 3 cycles, then released → IDLE with all outputs 0, then RESET_SP with `reg_write`=1, `mux_regdst`=2, `mux_mem2reg`=6, then FETCH.
- MEM_WAIT=2, ADD (opcode 0, funct 0x20):
  - `ins_load` pulses in cycle 4 of the instruction.
  - `alu_op`=1 in EXEC_R.
  - `reg_write`=1 with `mux_regdst`=1 in cycle 7; 7 cycles total.
- LB (0x20), MEM_WAIT=1:
  - `mdr_load` asserts after 2 MEM_RD cycles.
  - WB_MEM drives `adjsz_ctrl`=1; 9 cycles total.
- SH (0x29), MEM_WAIT=3:
  - `mem_write`=1 for exactly 4 consecutive cycles with `memow_ctrl`=2 and `mux_IorD`=1.
  - `rst` asserted in the 2nd write cycle → `mem_write`=0 the next cycle.
- BEQ with `zero`=1 → `pc_load`=1, `mux_pcin`=1. BNE with `zero`=1 → `pc_load`=0. JAL → `reg_write` with `mux_regdst`=3, then `pc_load` with `mux_pcin`=2.
- With `MC_CTRL_OVF_EXC_EN`: ADD with `overflow`=1 → no `reg_write`; `exc`=1, `pc_load`=1, `mux_pcin`=3 for one cycle. Without the macro → normal write-back.

Source files
------------

// File: rtl/mc_control_if.sv
// Control/datapath bundle for the multicycle MIPS controller: instruction fields
// and ALU flags toward the controller, register enables and mux selects back.
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       pc_load;
    logic       ins_load;
    logic       mem_write;
    logic       reg_write;
    logic       regA_load;
    logic       regB_load;
    logic       aluout_load;
    logic       mdr_load;
    logic       mux_alusrcA;
    logic [1:0] mux_alusrcB;
    logic [1:0] mux_pcin;
    logic [1:0] mux_IorD;
    logic [1:0] mux_regdst;
    logic [2:0] mux_mem2reg;
    logic [1:0] adjsz_ctrl;
    logic [1:0] memow_ctrl;
    logic [2:0] alu_op;
    logic       exc;

    modport master (
        input  opcode, funct, zero, overflow,
        output pc_load, ins_load, mem_write, reg_write, regA_load, regB_load,
               aluout_load, mdr_load, mux_alusrcA, mux_alusrcB, mux_pcin,
               mux_IorD, mux_regdst, mux_mem2reg, adjsz_ctrl, memow_ctrl,
               alu_op, exc
    );

    modport slave (
        output opcode, funct, zero, overflow,
        input  pc_load, ins_load, mem_write, reg_write, regA_load, regB_load,
               aluout_load, mdr_load, mux_alusrcA, mux_alusrcB, mux_pcin,
               mux_IorD, mux_regdst, mux_mem2reg, adjsz_ctrl, memow_ctrl,
               alu_op, exc
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with configurable memory wait states.
// Optional overflow trap enabled by defining MC_CTRL_OVF_EXC_EN.
module mc_control #(
    parameter int MEM_WAIT = 1,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_bad_mem_wait
        $error("mc_control: MEM_WAIT must be 0..15");
    end
    if (LINK_REG < 0 || LINK_REG > 31) begin : g_bad_link_reg
        $error("mc_control: LINK_REG must be 0..31");
    end

    typedef enum logic [4:0] {
        S_IDLE,
        S_RESET_SP,
        S_FETCH,
        S_FETCH_IR,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_WB_LUI,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_LD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JAL_LINK,
        S_JUMP
`ifdef MC_CTRL_OVF_EXC_EN
        , S_EXC
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       ovf_trap;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // {supported, alu_op} for an R-type funct field
    function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b1_001;
            6'h22:   return 4'b1_010;
            6'h24:   return 4'b1_011;
            6'h25:   return 4'b1_100;
            6'h2A:   return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    function automatic logic ovf_checked(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_ADDI) ||
               ((op == OP_RTYPE) && ((fn == 6'h20) || (fn == 6'h22)));
    endfunction

`ifdef MC_CTRL_OVF_EXC_EN
    assign ovf_trap = (state_q == S_WB_ALU) && bus.overflow &&
                      ovf_checked(bus.opcode, bus.funct);
`else
    assign ovf_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE:     state_d = S_RESET_SP;
            S_RESET_SP: state_d = S_FETCH;
            S_FETCH: begin
                if (wcnt_q == 4'd0) state_d = S_FETCH_IR;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_FETCH_IR: state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_RTYPE)                               state_d = S_EXEC_R;
                else if (bus.opcode == OP_ADDI)                           state_d = S_EXEC_I;
                else if (bus.opcode == OP_LUI)                            state_d = S_WB_LUI;
                else if (is_load(bus.opcode) || is_store(bus.opcode))     state_d = S_MEM_ADDR;
                else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE)    state_d = S_BRANCH;
                else if (bus.opcode == OP_J)                              state_d = S_JUMP;
                else if (bus.opcode == OP_JAL)                            state_d = S_JAL_LINK;
                else                                                      state_d = S_FETCH;
            end
            S_EXEC_R:   state_d = r_alu_op(bus.funct)[3] ? S_WB_ALU : S_FETCH;
            S_EXEC_I:   state_d = S_WB_ALU;
`ifdef MC_CTRL_OVF_EXC_EN
            S_WB_ALU:   state_d = ovf_trap ? S_EXC : S_FETCH;
            S_EXC:      state_d = S_FETCH;
`else
            S_WB_ALU:   state_d = S_FETCH;
`endif
            S_WB_LUI:   state_d = S_FETCH;
            S_MEM_ADDR: state_d = is_load(bus.opcode) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (wcnt_q == 4'd0) state_d = S_MEM_LD;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_MEM_LD:   state_d = S_WB_MEM;
            S_WB_MEM:   state_d = S_FETCH;
            S_MEM_WR: begin
                if (wcnt_q == 4'd0) state_d = S_FETCH;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_BRANCH:   state_d = S_FETCH;
            S_JAL_LINK: state_d = S_JUMP;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
        // Wait states reload the counter on entry, so a wait state lasts MEM_WAIT+1 cycles
        if ((state_d != state_q) &&
            ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR)))
            wcnt_d = WAIT_INIT;
    end

    always_comb begin
        bus.pc_load     = 1'b0;
        bus.ins_load    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.regA_load   = 1'b0;
        bus.regB_load   = 1'b0;
        bus.aluout_load = 1'b0;
        bus.mdr_load    = 1'b0;
        bus.mux_alusrcA = 1'b0;
        bus.mux_alusrcB = 2'd0;
        bus.mux_pcin    = 2'd0;
        bus.mux_IorD    = 2'd0;
        bus.mux_regdst  = 2'd0;
        bus.mux_mem2reg = 3'd0;
        bus.adjsz_ctrl  = 2'd0;
        bus.memow_ctrl  = 2'd0;
        bus.alu_op      = 3'd0;
        bus.exc         = 1'b0;
        case (state_q)
            S_RESET_SP: begin
                bus.reg_write   = 1'b1;
                bus.mux_regdst  = 2'd2;
                bus.mux_mem2reg = 3'd6;
            end
            S_FETCH_IR: begin
                bus.ins_load    = 1'b1;
                bus.pc_load     = 1'b1;
                bus.mux_alusrcB = 2'd1;
                bus.alu_op      = 3'd1;
            end
            S_DECODE: begin
                bus.regA_load   = 1'b1;
                bus.regB_load   = 1'b1;
                bus.aluout_load = 1'b1;
                bus.mux_alusrcB = 2'd3;
                bus.alu_op      = 3'd1;
            end
            S_EXEC_R: begin
                bus.mux_alusrcA = 1'b1;
                bus.aluout_load = 1'b1;
                bus.alu_op      = r_alu_op(bus.funct)[2:0];
            end
            S_EXEC_I: begin
                bus.mux_alusrcA = 1'b1;
                bus.mux_alusrcB = 2'd2;
                bus.aluout_load = 1'b1;
                bus.alu_op      = 3'd1;
            end
            S_WB_ALU: begin
                bus.reg_write   = !ovf_trap;
                bus.mux_mem2reg = 3'd1;
                bus.mux_regdst  = (bus.opcode == OP_RTYPE) ? 2'd1 : 2'd0;
            end
            S_WB_LUI: begin
                bus.reg_write   = 1'b1;
                bus.mux_mem2reg = 3'd2;
            end
            S_MEM_ADDR: begin
                bus.mux_alusrcA = 1'b1;
                bus.mux_alusrcB = 2'd2;
                bus.alu_op      = 3'd1;
                bus.aluout_load = 1'b1;
            end
            S_MEM_RD:   bus.mux_IorD = 2'd1;
            S_MEM_LD: begin
                bus.mux_IorD = 2'd1;
                bus.mdr_load = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.adjsz_ctrl = (bus.opcode == OP_LB) ? 2'd1 :
                                 (bus.opcode == OP_LH) ? 2'd2 : 2'd0;
            end
            S_MEM_WR: begin
                bus.mux_IorD   = 2'd1;
                bus.mem_write  = 1'b1;
                bus.memow_ctrl = (bus.opcode == OP_SB) ? 2'd1 :
                                 (bus.opcode == OP_SH) ? 2'd2 : 2'd0;
            end
            S_BRANCH: begin
                bus.mux_alusrcA = 1'b1;
                bus.alu_op      = 3'd2;
                bus.mux_pcin    = 2'd1;
                bus.pc_load     = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
            end
            S_JAL_LINK: begin
                bus.reg_write   = 1'b1;
                bus.mux_regdst  = 2'd3;
                bus.mux_mem2reg = 3'd3;
            end
            S_JUMP: begin
                bus.mux_pcin = 2'd2;
                bus.pc_load  = 1'b1;
            end
`ifdef MC_CTRL_OVF_EXC_EN
            S_EXC: begin
                bus.mux_pcin = 2'd3;
                bus.pc_load  = 1'b1;
                bus.exc      = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: three instances with MEM_WAIT = 1, 2, 3 share
// the instruction inputs; each test selects one instance and checks cycle by cycle.
module tb_mc_control;

    typedef struct packed {
        logic       pc_load;
        logic       ins_load;
        logic       mem_write;
        logic       reg_write;
        logic       regA_load;
        logic       regB_load;
        logic       aluout_load;
        logic       mdr_load;
        logic       alusrcA;
        logic [1:0] alusrcB;
        logic [1:0] pcin;
        logic [1:0] iord;
        logic [1:0] regdst;
        logic [2:0] mem2reg;
        logic [1:0] adjsz;
        logic [1:0] memow;
        logic [2:0] alu_op;
        logic       exc;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    outs_t      outs [3];
    outs_t      o;
    int         sel;
    int         cyc;
    int         checks;
    int         errors;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control_if bus ();
        assign bus.opcode   = opcode;
        assign bus.funct    = funct;
        assign bus.zero     = zero;
        assign bus.overflow = overflow;
        mc_control #(.MEM_WAIT(g + 1), .LINK_REG(31)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign outs[g] = {bus.pc_load, bus.ins_load, bus.mem_write, bus.reg_write,
                          bus.regA_load, bus.regB_load, bus.aluout_load, bus.mdr_load,
                          bus.mux_alusrcA, bus.mux_alusrcB, bus.mux_pcin, bus.mux_IorD,
                          bus.mux_regdst, bus.mux_mem2reg, bus.adjsz_ctrl, bus.memow_ctrl,
                          bus.alu_op, bus.exc};
    end

    assign o = outs[sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    // Hold reset 3 cycles, walk IDLE and RESET_SP, leave cyc=1 in the first FETCH
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        check("rst_held_outs", {4'b0, o}, 0);
        rst = 1'b0;
        check("idle_outs", {4'b0, o}, 0);
        step();
        check("rsp_reg_write", 32'(o.reg_write), 1);
        check("rsp_regdst", 32'(o.regdst), 2);
        check("rsp_mem2reg", 32'(o.mem2reg), 6);
        cyc = 0;
        step();
        check("fetch_outs", {4'b0, o}, 0);
    endtask

    // Next ins_load (start of the repeated instruction) lands on cycle L + W + 2
    task automatic next_ins(input string tag, input int exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            seen = o.ins_load;
        end
        check(tag, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic setup(input int s, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ov);
        sel = s; opcode = op; funct = fn; zero = z; overflow = ov;
        do_reset();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; sel = 0;
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;

        // ADD, W=2: FETCH 1-3, FETCH_IR 4, DECODE 5, EXEC_R 6, WB_ALU 7
        setup(1, 6'h00, 6'h20, 1'b0, 1'b0);
        run_to(3); check("add_fetch_no_ins", 32'(o.ins_load), 0);
        run_to(4); check("add_ins_load", 32'(o.ins_load), 1);
        check("add_ir_pc_load", 32'(o.pc_load), 1);
        check("add_ir_srcB", 32'(o.alusrcB), 1);
        run_to(5); check("add_dec_regA", 32'(o.regA_load), 1);
        check("add_dec_srcB", 32'(o.alusrcB), 3);
        run_to(6); check("add_exec_aluop", 32'(o.alu_op), 1);
        check("add_exec_srcA", 32'(o.alusrcA), 1);
        check("add_exec_aluout", 32'(o.aluout_load), 1);
        run_to(7); check("add_wb_reg_write", 32'(o.reg_write), 1);
        check("add_wb_regdst", 32'(o.regdst), 1);
        check("add_wb_mem2reg", 32'(o.mem2reg), 1);
        next_ins("add_len", 11);

        // SLT, W=1: EXEC_R 5, WB_ALU 6, length 6
        setup(0, 6'h00, 6'h2A, 1'b0, 1'b0);
        run_to(5); check("slt_aluop", 32'(o.alu_op), 7);
        run_to(6); check("slt_reg_write", 32'(o.reg_write), 1);
        next_ins("slt_len", 9);

        // OR, W=1
        setup(0, 6'h00, 6'h25, 1'b0, 1'b0);
        run_to(5); check("or_aluop", 32'(o.alu_op), 4);

        // ADDI, W=1: rt destination, sign-extended immediate
        setup(0, 6'h08, 6'h00, 1'b0, 1'b0);
        run_to(5); check("addi_srcB", 32'(o.alusrcB), 2);
        check("addi_aluop", 32'(o.alu_op), 1);
        run_to(6); check("addi_reg_write", 32'(o.reg_write), 1);
        check("addi_regdst", 32'(o.regdst), 0);
        next_ins("addi_len", 9);

        // Unsupported funct: no write-back, back to FETCH after EXEC_R
        setup(0, 6'h00, 6'h21, 1'b0, 1'b0);
        run_to(6); check("badfn_no_write", 32'(o.reg_write), 0);
        next_ins("badfn_len", 8);

        // LUI, W=1: length 5
        setup(0, 6'h0F, 6'h00, 1'b0, 1'b0);
        run_to(5); check("lui_reg_write", 32'(o.reg_write), 1);
        check("lui_mem2reg", 32'(o.mem2reg), 2);
        next_ins("lui_len", 8);

        // LB, W=1: MEM_ADDR 5, MEM_RD 6-7, MEM_LD 8, WB_MEM 9
        setup(0, 6'h20, 6'h00, 1'b0, 1'b0);
        run_to(5); check("lb_addr_aluout", 32'(o.aluout_load), 1);
        run_to(6); check("lb_rd_iord", 32'(o.iord), 1);
        check("lb_rd1_no_mdr", 32'(o.mdr_load), 0);
        run_to(7); check("lb_rd2_no_mdr", 32'(o.mdr_load), 0);
        run_to(8); check("lb_mdr_load", 32'(o.mdr_load), 1);
        check("lb_ld_iord", 32'(o.iord), 1);
        run_to(9); check("lb_reg_write", 32'(o.reg_write), 1);
        check("lb_adjsz", 32'(o.adjsz), 1);
        check("lb_mem2reg", 32'(o.mem2reg), 0);
        next_ins("lb_len", 12);

        // SH, W=3: FETCH 1-4, MEM_ADDR 7, MEM_WR 8-11, FETCH 12
        setup(2, 6'h29, 6'h00, 1'b0, 1'b0);
        run_to(7); check("sh_addr_no_write", 32'(o.mem_write), 0);
        for (int c = 8; c <= 11; c++) begin
            run_to(c);
            check("sh_mem_write", 32'(o.mem_write), 1);
            check("sh_memow", 32'(o.memow), 2);
            check("sh_iord", 32'(o.iord), 1);
        end
        run_to(12); check("sh_write_done", 32'(o.mem_write), 0);
        next_ins("sh_len", 16);

        // SH interrupted by reset in its second write cycle
        setup(2, 6'h29, 6'h00, 1'b0, 1'b0);
        run_to(9); check("sh_wr2_active", 32'(o.mem_write), 1);
        rst = 1'b1;
        step(); check("sh_rst_outs", {4'b0, o}, 0);
        rst = 1'b0;

        // BEQ/BNE, W=1: BRANCH at cycle 5
        setup(0, 6'h04, 6'h00, 1'b1, 1'b0);
        run_to(5); check("beq_z1_pc_load", 32'(o.pc_load), 1);
        check("beq_pcin", 32'(o.pcin), 1);
        check("beq_aluop", 32'(o.alu_op), 2);
        zero = 1'b0; #1;
        check("beq_z0_pc_load", 32'(o.pc_load), 0);
        next_ins("beq_len", 8);

        setup(0, 6'h05, 6'h00, 1'b1, 1'b0);
        run_to(5); check("bne_z1_pc_load", 32'(o.pc_load), 0);
        check("bne_pcin", 32'(o.pcin), 1);
        zero = 1'b0; #1;
        check("bne_z0_pc_load", 32'(o.pc_load), 1);

        // J and JAL, W=1
        setup(0, 6'h02, 6'h00, 1'b0, 1'b0);
        run_to(5); check("j_pc_load", 32'(o.pc_load), 1);
        check("j_pcin", 32'(o.pcin), 2);
        next_ins("j_len", 8);

        setup(0, 6'h03, 6'h00, 1'b0, 1'b0);
        run_to(5); check("jal_reg_write", 32'(o.reg_write), 1);
        check("jal_regdst", 32'(o.regdst), 3);
        check("jal_mem2reg", 32'(o.mem2reg), 3);
        run_to(6); check("jal_pc_load", 32'(o.pc_load), 1);
        check("jal_pcin", 32'(o.pcin), 2);
        next_ins("jal_len", 9);

        // Unknown opcode: straight back to FETCH after DECODE, length 4
        setup(0, 6'h3F, 6'h00, 1'b0, 1'b0);
        next_ins("ill_first_ins", 3);
        next_ins("ill_len", 7);

        // ADD with overflow, W=2
        setup(1, 6'h00, 6'h20, 1'b0, 1'b1);
`ifdef MC_CTRL_OVF_EXC_EN
        run_to(7); check("ovf_no_reg_write", 32'(o.reg_write), 0);
        check("ovf_wb_no_exc", 32'(o.exc), 0);
        run_to(8); check("ovf_exc", 32'(o.exc), 1);
        check("ovf_pc_load", 32'(o.pc_load), 1);
        check("ovf_pcin", 32'(o.pcin), 3);
        next_ins("ovf_len", 12);
`else
        run_to(7); check("ovf_reg_write", 32'(o.reg_write), 1);
        check("ovf_exc_tied", 32'(o.exc), 0);
        run_to(8); check("ovf_next_exc", 32'(o.exc), 0);
        next_ins("ovf_len", 11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
